stack_ptr_unit: RTL and testbench

- Parametrised successor to the 8-bit stack pointer register.
- Adds configurable width, bounded stack region [STACK_LIMIT, STACK_BASE], full/empty/depth status, signed multi-word adjust, and sticky overflow/underflow fault flags.
- Sits beside the datapath/control FSM and drives the stack address into memory address muxing.
- Stack grows downward: push decrements, pop increments.

---
 rtl/stack_ptr_unit.sv | 116 +++++++++++
 tb/tb_stack_ptr_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/stack_ptr_unit.sv
// Downward-growing stack pointer with a bounded region, status, signed adjust and sticky faults.
// Define SP_SHADOW_EN to add a shadow SP that sp_swap exchanges with the live SP.
module stack_ptr_unit #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] STACK_BASE = {ADDR_W{1'b1}},
  parameter logic [ADDR_W-1:0] STACK_LIMIT = STACK_BASE - ADDR_W'(15),
  parameter int OFF_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_sp,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              sp_push,
  input  logic              sp_pop,
  input  logic              sp_adj,
  input  logic [OFF_W-1:0]  adj_off,
  input  logic              clr_err,
  input  logic              sp_swap,
  output logic [ADDR_W-1:0] sp_out,
  output logic [ADDR_W-1:0] shadow_out,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] depth,
  output logic              ovf,
  output logic              unf
);

  // Two spare bits so that SP plus a positive offset cannot alias a negative sum.
  localparam int RW = ADDR_W + 2;

  logic [ADDR_W-1:0]   sp_q;
  logic [ADDR_W-1:0]   shadow_q;
  logic [ADDR_W-1:0]   sp_next;
  logic                swap_req;
  logic                ovf_set;
  logic                unf_set;
  logic                in_range;
  logic signed [RW-1:0] adj_sum;
  logic                adj_low;
  logic                adj_high;

`ifdef SP_SHADOW_EN
  assign swap_req = sp_swap;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= STACK_BASE;
    end else if (!load_sp && sp_swap) begin
      shadow_q <= sp_q;
    end
  end
`else
  logic unused_swap;
  assign unused_swap = sp_swap;
  assign swap_req    = 1'b0;
  assign shadow_q    = '0;
`endif

  assign full     = (sp_q <= STACK_LIMIT);
  assign empty    = (sp_q >= STACK_BASE);
  assign in_range = (sp_q >= STACK_LIMIT) && (sp_q <= STACK_BASE);
  assign depth    = in_range ? (STACK_BASE - sp_q) : '0;

  assign adj_sum  = $signed({2'b00, sp_q}) +
                    $signed({{(RW-OFF_W){adj_off[OFF_W-1]}}, adj_off});
  assign adj_low  = adj_sum < $signed({2'b00, STACK_LIMIT});
  assign adj_high = adj_sum > $signed({2'b00, STACK_BASE});

  // Only the highest-priority command acts; rejected commands leave SP alone.
  always_comb begin
    sp_next = sp_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (load_sp) begin
      sp_next = sp_in;
    end else if (swap_req) begin
      sp_next = shadow_q;
    end else if (sp_adj) begin
      if (adj_low) begin
        ovf_set = 1'b1;
      end else if (adj_high) begin
        unf_set = 1'b1;
      end else begin
        sp_next = adj_sum[ADDR_W-1:0];
      end
    end else if (sp_push && !sp_pop) begin
      if (full) begin
        ovf_set = 1'b1;
      end else begin
        sp_next = sp_q - ADDR_W'(1);
      end
    end else if (sp_pop && !sp_push) begin
      if (empty) begin
        unf_set = 1'b1;
      end else begin
        sp_next = sp_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= STACK_BASE;
      ovf  <= 1'b0;
      unf  <= 1'b0;
    end else begin
      sp_q <= sp_next;
      ovf  <= (ovf & ~clr_err) | ovf_set;
      unf  <= (unf & ~clr_err) | unf_set;
    end
  end

  assign sp_out     = sp_q;
  assign shadow_out = shadow_q;

endmodule

// File: tb/tb_stack_ptr_unit.sv
// Scoreboard bench for stack_ptr_unit with the default 8-bit region [F0, FF].
// Follows SP_SHADOW_EN the same way as the design.
module tb_stack_ptr_unit;

  localparam int BASE  = 'hFF;
  localparam int LIMIT = 'hF0;
  localparam int W     = 28;
`ifdef SP_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_sp = 1'b0;
  logic [7:0] sp_in = '0;
  logic       sp_push = 1'b0;
  logic       sp_pop = 1'b0;
  logic       sp_adj = 1'b0;
  logic [3:0] adj_off = '0;
  logic       clr_err = 1'b0;
  logic       sp_swap = 1'b0;
  logic [7:0] sp_out;
  logic [7:0] shadow_out;
  logic       full;
  logic       empty;
  logic [7:0] depth;
  logic       ovf;
  logic       unf;

  stack_ptr_unit dut (
    .clk(clk), .reset(reset), .load_sp(load_sp), .sp_in(sp_in),
    .sp_push(sp_push), .sp_pop(sp_pop), .sp_adj(sp_adj), .adj_off(adj_off),
    .clr_err(clr_err), .sp_swap(sp_swap), .sp_out(sp_out),
    .shadow_out(shadow_out), .full(full), .empty(empty), .depth(depth),
    .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_step   = 0;

  int m_sp, m_sh;
  bit m_ovf, m_unf;

  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s @step %0d: got %0h expected %0h", tag, n_step, got, exp);
  endtask

  function automatic logic [W-1:0] pack_model();
    logic [7:0] d;
    logic       f, e;
    f = (m_sp <= LIMIT);
    e = (m_sp >= BASE);
    d = (m_sp >= LIMIT && m_sp <= BASE) ? 8'(BASE - m_sp) : 8'h00;
    return {8'(m_sp), 8'(m_sh), f, e, d, m_ovf, m_unf};
  endfunction

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input bit rst, input bit ld, input logic [7:0] din, input bit push,
                      input bit pop, input bit adj, input logic [3:0] off,
                      input bit clr, input bit swap);
    int r, t;
    bit os, us;
    logic [W-1:0] e;
    reset = rst; load_sp = ld; sp_in = din; sp_push = push; sp_pop = pop;
    sp_adj = adj; adj_off = off; clr_err = clr; sp_swap = swap;
    os = 1'b0; us = 1'b0;
    if (rst) begin
      m_sp = BASE; m_sh = SHADOW ? BASE : 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (ld) m_sp = int'(din);
      else if (SHADOW && swap) begin
        t = m_sp; m_sp = m_sh; m_sh = t;
      end else if (adj) begin
        r = m_sp + (off >= 8 ? int'(off) - 16 : int'(off));
        if (r < LIMIT) os = 1'b1;
        else if (r > BASE) us = 1'b1;
        else m_sp = r;
      end else if (push && !pop) begin
        if (m_sp <= LIMIT) os = 1'b1; else m_sp = m_sp - 1;
      end else if (pop && !push) begin
        if (m_sp >= BASE) us = 1'b1; else m_sp = m_sp + 1;
      end
      m_ovf = (m_ovf && !clr) || os;
      m_unf = (m_unf && !clr) || us;
    end
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
    n_step++;
    e = exp_q.pop_front();
    check("sp_out", 32'(sp_out), 32'(e[27:20]));
    check("shadow_out", 32'(shadow_out), 32'(e[19:12]));
    check("full", 32'(full), 32'(e[11]));
    check("empty", 32'(empty), 32'(e[10]));
    check("depth", 32'(depth), 32'(e[9:2]));
    check("ovf", 32'(ovf), 32'(e[1]));
    check("unf", 32'(unf), 32'(e[0]));
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 0);
  endtask

  task automatic load(input logic [7:0] v);
    step(0, 1, v, 0, 0, 0, 4'h0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    m_sp = BASE; m_sh = SHADOW ? BASE : 0; m_ovf = 0; m_unf = 0;
    @(posedge clk);
    #1;
    step(1, 0, 8'h00, 0, 0, 0, 4'h0, 0, 0);
    idle();
    // Fill the region, overflow once, then clear.
    for (int i = 0; i < 15; i++) step(0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0);
    step(0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 0);
    // clr_err together with a new overflow: the fault must stay set.
    step(0, 0, 8'h00, 1, 0, 0, 4'h0, 1, 0);
    step(0, 0, 8'h00, 0, 0, 0, 4'h0, 1, 0);
    // Underflow from empty, then simultaneous push+pop.
    step(1, 0, 8'h00, 0, 0, 0, 4'h0, 0, 0);
    step(0, 0, 8'h00, 0, 1, 0, 4'h0, 0, 0);
    step(0, 0, 8'h00, 1, 1, 0, 4'h0, 0, 0);
    // Signed adjust: below limit, in range, above base.
    load(8'hF4);
    step(0, 0, 8'h00, 0, 0, 1, 4'hA, 1, 0);
    step(0, 0, 8'h00, 0, 0, 1, 4'h3, 1, 0);
    load(8'hFE);
    step(0, 0, 8'h00, 0, 0, 1, 4'h3, 0, 0);
    step(0, 0, 8'h00, 0, 0, 1, 4'h1, 1, 0);
    step(0, 0, 8'h00, 0, 0, 1, 4'h8, 0, 0);
    // Load beats push; out-of-range values; reset beats push.
    load(8'hF7);
    step(0, 1, 8'h20, 1, 0, 0, 4'h0, 0, 0);
    step(0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0);
    load(8'h05);
    step(0, 0, 8'h00, 0, 0, 1, 4'h9, 1, 0);
    step(0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0, 4'h0, 0, 0);
    // Swap, swap back, and load winning over swap.
    load(8'hF8);
    step(0, 0, 8'h00, 0, 0, 0, 4'h0, 0, 1);
    step(0, 0, 8'h00, 1, 0, 0, 4'h0, 0, 1);
    step(0, 1, 8'hF2, 0, 0, 0, 4'h0, 0, 1);
    step(0, 0, 8'h00, 0, 0, 1, 4'h2, 0, 1);
    // Randomised mix, mostly near the region so both bounds get exercised.
    for (int i = 0; i < 400; i++) begin
      int k;
      logic [7:0] v;
      k = $urandom_range(0, 99);
      v = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range('hEC, 'hFF));
      step(k < 2, k >= 2 && k < 8, v, $urandom_range(0, 1), $urandom_range(0, 1),
           k >= 8 && k < 30, 4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
